// File: rtl/cfg_reg_apb_bridge.sv
// APB4 completer that turns each APB transfer into a single-cycle register-bank
// strobe. It decodes the fixed register map and rejects illegal accesses with
// PSLVERR. Every legal read produces exactly one ren pulse, so read-to-clear
// registers in the bank clear once per access.
module cfg_reg_apb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'hC0F16000,
    parameter bit          REQ_PRIV  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    input  logic [2:0]  pprot,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        wen,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        ren,
    output logic [31:0] raddr,
    input  logic [31:0] rdata,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {StIdle, StDecode, StStrobe, StResp} state_e;

    state_e      state_q, state_d;

    // Transfer fields captured in the setup phase
    logic [31:0] addr_q;
    logic [31:0] pwdata_q;
    logic        write_q;
    logic [3:0]  strb_q;
    logic        priv_q;
    logic        err_q;

    logic [31:0] prdata_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic [31:0] raddr_q;
    logic [7:0]  err_cnt_q;

    logic [31:0] offset;
    logic        mapped;
    logic        read_only;
    logic        dec_err;
    logic        setup;

    // Only the privileged bit of pprot matters here
    logic        unused_prot;
    assign unused_prot = ^pprot[2:1];

    assign setup = psel && !penable;

    // Decode the latched address against the register map and flag illegal accesses
    always_comb begin
        offset    = addr_q - BASE_ADDR;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (offset)
            32'h0000_0000, 32'h0000_0004, 32'h0000_0BAC: read_only = 1'b1;
            32'h0000_0010, 32'h0000_0020, 32'h0000_0B60: read_only = 1'b0;
            default:                                     mapped    = 1'b0;
        endcase
        dec_err = (addr_q[1:0] != 2'b00)
               || !mapped
               || (write_q && read_only)
               || (write_q && (strb_q != 4'hF))
               || (REQ_PRIV && write_q && !priv_q);
    end

    // Next-state logic; dropping psel before the response aborts silently
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (setup) state_d = StDecode;
            end
            StDecode: begin
                if (!psel)        state_d = StIdle;
                else if (dec_err) state_d = StResp;
                else              state_d = StStrobe;
            end
            StStrobe: begin
                if (!psel) state_d = StIdle;
                else       state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the setup-phase fields and the decode verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            pwdata_q <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            priv_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == StIdle && setup) begin
                addr_q   <= paddr;
                pwdata_q <= pwdata;
                write_q  <= pwrite;
                strb_q   <= pstrb;
                priv_q   <= pprot[0];
            end
            if (state_q == StDecode) begin
                err_q <= dec_err;
            end
        end
    end

    // Strobe address/data, read data capture and the saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            prdata_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            // Load the bank-facing address/data as the strobe cycle begins
            if (state_q == StDecode && state_d == StStrobe) begin
                if (write_q) begin
                    waddr_q <= addr_q;
                    wdata_q <= pwdata_q;
                end else begin
                    raddr_q <= addr_q;
                end
            end
            if (state_q == StDecode && state_d == StResp && !write_q) begin
                prdata_q <= '0;
            end
            if (state_q == StStrobe && !write_q) begin
                prdata_q <= rdata;
            end
            if (state_q == StResp && err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Errored transfers never reach StStrobe, so strobes need no error qualifier
    assign wen     = (state_q == StStrobe) && write_q;
    assign ren     = (state_q == StStrobe) && !write_q;
    assign pready  = (state_q == StResp);
    assign pslverr = (state_q == StResp) && err_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign raddr   = raddr_q;
    assign prdata  = prdata_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_cfg_reg_apb_bridge.sv
// Directed bench for cfg_reg_apb_bridge: a vector table of single transfers,
// plus hand-written sequences for abort, reset, saturation and back-to-back cases.
// A second instance with REQ_PRIV=1 shares the APB inputs for the privilege check.
module tb_cfg_reg_apb_bridge;

    localparam logic [31:0] Base = 32'hC0F16000;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] bank;

    logic        pready, pslverr, wen, ren;
    logic [31:0] prdata, waddr, wdata, raddr;
    logic [7:0]  err_cnt;

    logic        p_pready, p_pslverr, p_wen, p_ren;
    logic [31:0] p_prdata, p_waddr, p_wdata, p_raddr;
    logic [7:0]  p_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    cfg_reg_apb_bridge #(.BASE_ADDR(Base), .REQ_PRIV(1'b0)) u_dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(bank), .err_cnt(err_cnt)
    );

    cfg_reg_apb_bridge #(.BASE_ADDR(Base), .REQ_PRIV(1'b1)) u_priv (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(p_pready), .prdata(p_prdata), .pslverr(p_pslverr),
        .wen(p_wen), .waddr(p_waddr), .wdata(p_wdata),
        .ren(p_ren), .raddr(p_raddr), .rdata(bank), .err_cnt(p_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [11:0] off;
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  p;
        logic [31:0] bank;
        logic        err;
        logic        perr;
    } vec_t;

    typedef struct {
        int          wen_n;
        int          ren_n;
        int          rdy_cyc;
        logic        slverr;
        logic [31:0] prdata;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        int          p_wen_n;
        int          p_rdy;
        logic        p_slverr;
        logic [7:0]  cnt;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One APB transfer starting right after a rising edge; bounded to 8 cycles.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, output res_t r);
        r = '{default: 0};
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = p;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 1; c <= 8 && r.rdy_cyc == 0; c++) begin
            @(negedge clk);
            if (wen) begin r.wen_n++; r.waddr = waddr; r.wdata = wdata; end
            if (ren) begin r.ren_n++; r.raddr = raddr; end
            if (p_wen) r.p_wen_n++;
            if (p_pready && r.p_rdy == 0) begin r.p_rdy = c; r.p_slverr = p_pslverr; end
            if (pready) begin r.rdy_cyc = c; r.slverr = pslverr; r.prdata = prdata; end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        r.cnt = err_cnt;
    endtask

    // wen and ren must never be high together
    always @(negedge clk) begin
        if (!rst && wen && ren) begin
            n_err++;
            $display("FAIL wen_ren_overlap: got wen=%b ren=%b, expected not both", wen, ren);
        end
    end

    vec_t       vecs[12];
    res_t       r, r2;
    logic [7:0] exp_cnt;
    int         seen;

    initial begin
        vecs[0]  = '{1'b1, 12'h020, 32'h0000_0005, 4'hF, 3'b000, 32'h0,         1'b0, 1'b1};
        vecs[1]  = '{1'b0, 12'h000, 32'h0,         4'hF, 3'b000, 32'h0000_0C03, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 12'h008, 32'h0,         4'hF, 3'b000, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 12'hBAC, 32'h0,         4'hF, 3'b000, 32'hABCD_1234, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 12'h011, 32'h0,         4'hF, 3'b000, 32'h1111_2222, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 12'hBAC, 32'h0000_0077, 4'hF, 3'b001, 32'h0,         1'b1, 1'b1};
        vecs[6]  = '{1'b1, 12'h010, 32'h1234_5678, 4'h3, 3'b001, 32'h0,         1'b1, 1'b1};
        vecs[7]  = '{1'b1, 12'hB60, 32'h0000_1234, 4'hF, 3'b000, 32'h0,         1'b0, 1'b1};
        vecs[8]  = '{1'b1, 12'hB60, 32'h0000_5678, 4'hF, 3'b001, 32'h0,         1'b0, 1'b0};
        vecs[9]  = '{1'b0, 12'h004, 32'h0,         4'hF, 3'b000, 32'h0000_0055, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 12'h000, 32'h0000_0001, 4'hF, 3'b001, 32'h0,         1'b1, 1'b1};
        vecs[11] = '{1'b1, 12'h010, 32'hCAFE_F00D, 4'hF, 3'b001, 32'h0,         1'b0, 1'b0};

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; bank = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", {31'b0, pready}, 32'h0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("rst_wen", {31'b0, wen}, 32'h0);
        chk("rst_ren", {31'b0, ren}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_waddr", waddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_raddr", raddr, 32'h0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 8'd0;

        // Table-driven single transfers
        for (int i = 0; i < 12; i++) begin
            bank = vecs[i].bank;
            xfer(vecs[i].w, Base + {20'b0, vecs[i].off}, vecs[i].d, vecs[i].s, vecs[i].p, r);
            if (vecs[i].err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("v%0d_rdy_cycle", i), r.rdy_cyc, vecs[i].err ? 2 : 3);
            chk($sformatf("v%0d_pslverr", i), {31'b0, r.slverr}, {31'b0, vecs[i].err});
            chk($sformatf("v%0d_wen_count", i), r.wen_n, (vecs[i].w && !vecs[i].err) ? 1 : 0);
            chk($sformatf("v%0d_ren_count", i), r.ren_n, (!vecs[i].w && !vecs[i].err) ? 1 : 0);
            if (vecs[i].w && !vecs[i].err) begin
                chk($sformatf("v%0d_waddr", i), r.waddr, Base + {20'b0, vecs[i].off});
                chk($sformatf("v%0d_wdata", i), r.wdata, vecs[i].d);
            end
            if (!vecs[i].w) begin
                chk($sformatf("v%0d_prdata", i), r.prdata, vecs[i].err ? 32'h0 : vecs[i].bank);
                if (!vecs[i].err) chk($sformatf("v%0d_raddr", i), r.raddr, Base + {20'b0, vecs[i].off});
            end
            chk($sformatf("v%0d_err_cnt", i), {24'b0, r.cnt}, {24'b0, exp_cnt});
            chk($sformatf("v%0d_priv_pslverr", i), {31'b0, r.p_slverr}, {31'b0, vecs[i].perr});
            chk($sformatf("v%0d_priv_rdy", i), r.p_rdy, vecs[i].perr ? 2 : 3);
            chk($sformatf("v%0d_priv_wen", i), r.p_wen_n, (vecs[i].w && !vecs[i].perr) ? 1 : 0);
        end

        // psel dropped in DECODE: no strobe, no response, then a normal transfer
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = Base + 32'h20;
        pwdata = 32'h0BAD_0BAD; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        psel = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wen || ren || pready) seen++;
            @(posedge clk); #1;
        end
        chk("abort_no_activity", seen, 0);
        chk("abort_wdata_held", wdata, 32'hCAFE_F00D);
        bank = 32'h0000_0099;
        xfer(1'b0, Base + 32'h004, 32'h0, 4'hF, 3'b000, r);
        chk("after_abort_rdy", r.rdy_cyc, 3);
        chk("after_abort_ren", r.ren_n, 1);
        chk("after_abort_prdata", r.prdata, 32'h0000_0099);

        // Reset asserted during STROBE
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = Base + 32'h10;
        pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("strobe_before_rst", {31'b0, wen}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("post_rst_wen", {31'b0, wen}, 32'h0);
        chk("post_rst_pready", {31'b0, pready}, 32'h0);
        chk("post_rst_waddr", waddr, 32'h0);
        chk("post_rst_wdata", wdata, 32'h0);
        chk("post_rst_prdata", prdata, 32'h0);
        chk("post_rst_err_cnt", {24'b0, err_cnt}, 32'h0);
        @(posedge clk); #1;
        exp_cnt = 8'd0;

        // 256 consecutive errors: counter saturates at 255
        bank = 32'h0;
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, Base + 32'h008, 32'h0, 4'hF, 3'b000, r);
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("sat_%0d_err_cnt", i), {24'b0, r.cnt}, {24'b0, exp_cnt});
        end
        chk("sat_final", {24'b0, err_cnt}, 32'h0000_00FF);

        // Back-to-back reads of 0x004: exactly two ren pulses
        bank = 32'h0000_0044;
        xfer(1'b0, Base + 32'h004, 32'h0, 4'hF, 3'b000, r);
        xfer(1'b0, Base + 32'h004, 32'h0, 4'hF, 3'b000, r2);
        chk("b2b_ren_total", r.ren_n + r2.ren_n, 2);
        chk("b2b_second_rdy", r2.rdy_cyc, 3);
        chk("b2b_second_prdata", r2.prdata, 32'h0000_0044);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_reg_apb_bridge.md
# cfg_reg_apb_bridge

APB4 completer that converts APB4 transfers into single-cycle register-port strobes (`wen`/`waddr`/`wdata`, `ren`/`raddr`/`rdata`) for the bridge's config/status register bank. It sits between the APB4 configuration bus and the register bank:

- decodes the fixed register map;
- rejects illegal accesses with PSLVERR;
- guarantees exactly one `ren` pulse per read, so read-to-clear status registers clear once per access.

## Interface
Parameters:
- `BASE_ADDR`, 32'hC0F16000, absolute base of the register map.
- `REQ_PRIV`, 0, when 1 writes with `pprot[0]`=0 are rejected.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `psel` in 1: APB select.
- `penable` in 1: APB access phase.
- `pwrite` in 1: 1 = write.
- `paddr` in 32: APB address.
- `pwdata` in 32: write data.
- `pstrb` in 4: write byte strobes.
- `pprot` in 3: protection; only bit 0 (privileged) is used.
- `pready` out 1: transfer complete.
- `prdata` out 32: read data, registered.
- `pslverr` out 1: error response, valid when `pready`=1.
- `wen` out 1: write strobe to the register bank.
- `waddr` out 32: absolute write address.
- `wdata` out 32: write data.
- `ren` out 1: read strobe to the register bank.
- `raddr` out 32: absolute read address.
- `rdata` in 32: combinational read data from the register bank, valid in the same cycle as `ren`.
- `err_cnt` out 8: saturating count of error responses.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x000, read-only.
  - 0x004, read-only.
  - 0x010, read/write.
  - 0x020, read/write.
  - 0xB60, read/write.
  - 0xBAC, read-only.
- Error conditions (latched in DECODE):
  - `paddr[1:0]`≠0.
  - Address not in the map.
  - Write to a read-only offset.
  - Write with `pstrb`≠4'hF.
  - `REQ_PRIV`=1 and write with `pprot[0]`=0.
- An error suppresses `wen`/`ren` completely.
- FSM states: IDLE, DECODE, STROBE, RESP.
  - IDLE: on `psel`=1 and `penable`=0, latch `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot`; go to DECODE.
  - DECODE: evaluate the error conditions. Error → RESP with `pslverr`=1. Otherwise → STROBE.
  - STROBE: exactly one cycle.
    - Write: `wen`=1 with `waddr`/`wdata` = latched values.
    - Read: `ren`=1 with `raddr` = latched address; `rdata` is captured into `prdata` at the end of this cycle.
    - Then go to RESP.
  - RESP: `pready`=1, `pslverr` per decode → IDLE. On error, increment `err_cnt` (saturates at 255).
- `prdata` holds its last value between reads; it is forced to 0 on an errored read.
- `waddr`, `raddr`, `wdata` hold their last values when not strobing.
- Protocol violation: if `psel`=0 in DECODE or STROBE, return to IDLE with no response.
  - A strobe already issued in STROBE is not repeated.
  - No strobe is issued if the abort happens in DECODE.
- Back-to-back transfers: a new setup phase seen in the cycle after RESP is accepted from IDLE normally.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, `wen`=0, `ren`=0, `waddr`=0, `raddr`=0, `wdata`=0, `err_cnt`=0; state = IDLE.
- Reset asserted mid-transfer: next cycle is IDLE with all strobes deasserted; the pending transfer gets no response.
- Cycle sequence (T0 = setup phase):
  - T1 DECODE, `pready`=0.
  - T2 STROBE, `wen`/`ren`=1, `pready`=0.
  - T3 RESP, `pready`=1.
- Legal transfer: 2 wait states, completes at T3.
- Errored transfer: 1 wait state, completes at T2; no strobe.
- `wen`/`ren` are high for exactly 1 cycle per legal access and are never both high.
- `pready` is high for exactly 1 cycle per response.
- `prdata` is valid in RESP.

## Test plan
- **Legal write:** write 0x0000_0005 to offset 0x020 with `pstrb`=F. Required:
  - `wen`=1 for one cycle at T2, `waddr`=0xC0F16020, `wdata`=5.
  - `pready` at T3, `pslverr`=0.
- **Legal read:** read offset 0x000 with the bank returning 0x0000_0C03 during `ren`. Required:
  - exactly one `ren` pulse, `raddr`=0xC0F16000;
  - `prdata`=0x0000_0C03 at T3, `pslverr`=0.
- **Illegal write to read-only:** write to offset 0xBAC. Required:
  - no `wen`;
  - `pready` and `pslverr`=1 at T2;
  - `err_cnt` 0→1.
- **Strobe and address errors:** `pstrb`=4'h3 write to 0x010; read of unmapped 0x008; read of 0x011. Each must produce:
  - `pslverr`=1, no strobe;
  - `prdata`=0 on the reads;
  - `err_cnt` incremented each time.
- **Privilege check (`REQ_PRIV`=1):**
  - write 0xB60 with `pprot`=3'b000 → error, no `wen`;
  - same write with `pprot`=3'b001 → `wen`=1, no error.
- **Boundaries:**
  - 256 consecutive errors → `err_cnt` saturates at 255;
  - `psel` dropped in DECODE → no strobe, FSM returns to IDLE;
  - `rst` asserted in STROBE → next cycle all outputs at reset values;
  - two back-to-back reads of 0x004 → exactly two `ren` pulses.
